// File: rtl/cdc_arb_pkg.sv
// Shared types and width helpers for the CDC transmit arbiter.
package cdc_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_LOW  = 2'd2,
        WAIT_HIGH = 2'd3
    } arb_state_t;

    localparam int REQ_CNT_W  = 16;
    localparam int XFER_CNT_W = 32;

    // Source-ID width for a given requester count; never narrower than one bit.
    function automatic int id_width(input int nreq);
        return (nreq <= 2) ? 1 : $clog2(nreq);
    endfunction

    function automatic int cnt_width(input int max_count);
        return (max_count < 2) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first valid requester strictly above the
// pointer, otherwise the lowest valid one (i.e. wrap-around from pointer+1).
module rr_arbiter
    import cdc_arb_pkg::*;
#(
    parameter int G_NREQ = 4,
    parameter int G_IDW  = id_width(G_NREQ)
) (
    input  logic [G_NREQ-1:0] valid,
    input  logic [G_IDW-1:0]  ptr,
    output logic [G_NREQ-1:0] grant,
    output logic [G_IDW-1:0]  grant_id,
    output logic              any_valid
);

    logic found;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        for (int j = 0; j < G_NREQ; j++) begin
            if (!found && valid[j] && (j > int'(ptr))) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                grant_id = G_IDW'(j);
            end
        end
        // Wrapped pass: nothing above the pointer was asking.
        for (int j = 0; j < G_NREQ; j++) begin
            if (!found && valid[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                grant_id = G_IDW'(j);
            end
        end
    end

    assign any_valid = |valid;

endmodule

// File: rtl/cdc_tx_arbiter.sv
// Domain-A scheduler sharing one 2-phase CDC channel between G_NREQ requesters.
// Optional transfer/accept statistics are built when CDC_ARB_STATS_EN is defined.
module cdc_tx_arbiter
    import cdc_arb_pkg::*;
#(
    parameter int G_NREQ    = 4,
    parameter int G_WIDTH   = 8,
    parameter int G_IDW     = 2,
    parameter int G_TIMEOUT = 15
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [G_NREQ-1:0]         i_req_valid,
    input  logic [G_NREQ*G_WIDTH-1:0] i_req_data,
    output logic [G_NREQ-1:0]         o_req_ready,
    output logic                      o_cdc_valid,
    output logic [G_IDW+G_WIDTH-1:0]  o_cdc_data,
    input  logic                      i_cdc_ready,
    output logic                      o_busy,
    output logic [G_IDW-1:0]          o_grant_id,
    output logic                      o_timeout_err
`ifdef CDC_ARB_STATS_EN
    ,
    output logic [XFER_CNT_W-1:0]     o_xfer_count,
    output logic [G_NREQ*REQ_CNT_W-1:0] o_req_count
`endif
);

    localparam int CNT_W = cnt_width(G_TIMEOUT);

    arb_state_t                state_reg, state_next;
    logic [G_IDW-1:0]          ptr_reg;
    logic [G_IDW+G_WIDTH-1:0]  hold_reg;
    logic [G_IDW-1:0]          grant_id_reg;
    logic [CNT_W-1:0]          tmo_cnt_reg;
    logic                      tmo_err_reg;

    logic [G_NREQ-1:0]         win_grant;
    logic [G_IDW-1:0]          win_id;
    logic                      any_valid;
    logic [G_WIDTH-1:0]        req_word [G_NREQ];
    logic                      can_accept;
    logic                      accept;
    logic                      tmo_hit;
    logic [CNT_W-1:0]          tmo_cnt_inc;

    for (genvar gi = 0; gi < G_NREQ; gi++) begin : g_unpack
        assign req_word[gi] = i_req_data[gi*G_WIDTH +: G_WIDTH];
    end

    rr_arbiter #(
        .G_NREQ (G_NREQ),
        .G_IDW  (G_IDW)
    ) u_rr (
        .valid     (i_req_valid),
        .ptr       (ptr_reg),
        .grant     (win_grant),
        .grant_id  (win_id),
        .any_valid (any_valid)
    );

    // Ready is only trusted in IDLE; the stale-high window after issue is
    // absorbed by WAIT_LOW, so no grant can slip in there.
    assign can_accept  = (state_reg == IDLE) && i_cdc_ready && !i_rst;
    assign accept      = can_accept && any_valid;
    assign tmo_cnt_inc = tmo_cnt_reg + CNT_W'(1);
    assign tmo_hit     = (state_reg == WAIT_LOW) && i_cdc_ready
                         && (tmo_cnt_inc == CNT_W'(G_TIMEOUT));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) state_next = ISSUE;
            end
            ISSUE: begin
                state_next = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (!i_cdc_ready) begin
                    state_next = WAIT_HIGH;
                end else if (tmo_hit) begin
                    state_next = IDLE;
                end
            end
            WAIT_HIGH: begin
                if (i_cdc_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        o_req_ready = '0;
        if (can_accept) o_req_ready = win_grant;
        o_cdc_valid = (state_reg == ISSUE);
        o_busy      = (state_reg != IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr_reg      <= G_IDW'(G_NREQ - 1);
            hold_reg     <= '0;
            grant_id_reg <= '0;
            tmo_cnt_reg  <= '0;
            tmo_err_reg  <= 1'b0;
        end else begin
            if (accept) begin
                hold_reg     <= {win_id, req_word[win_id]};
                grant_id_reg <= win_id;
                ptr_reg      <= win_id;
            end
            if (state_reg == ISSUE) begin
                tmo_cnt_reg <= '0;
            end else if ((state_reg == WAIT_LOW) && i_cdc_ready) begin
                tmo_cnt_reg <= tmo_cnt_inc;
            end
            if (tmo_hit) tmo_err_reg <= 1'b1;
        end
    end

    assign o_cdc_data    = hold_reg;
    assign o_grant_id    = grant_id_reg;
    assign o_timeout_err = tmo_err_reg;

`ifdef CDC_ARB_STATS_EN
    logic [XFER_CNT_W-1:0] xfer_cnt_reg;

    // Only a full handshake counts; timeouts leave through WAIT_LOW.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            xfer_cnt_reg <= '0;
        end else if ((state_reg == WAIT_HIGH) && i_cdc_ready) begin
            xfer_cnt_reg <= xfer_cnt_reg + XFER_CNT_W'(1);
        end
    end

    assign o_xfer_count = xfer_cnt_reg;

    for (genvar gi = 0; gi < G_NREQ; gi++) begin : g_req_cnt
        logic [REQ_CNT_W-1:0] cnt_reg;

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                cnt_reg <= '0;
            end else if (accept && win_grant[gi] && (cnt_reg != {REQ_CNT_W{1'b1}})) begin
                cnt_reg <= cnt_reg + REQ_CNT_W'(1);
            end
        end

        assign o_req_count[gi*REQ_CNT_W +: REQ_CNT_W] = cnt_reg;
    end
`endif

endmodule
